// File: rtl/bcd_scan_display.sv
// bcd_scan_display: scans a packed 3-digit BCD value onto a common-anode
// 7-segment module. It snapshots the value once per frame, optionally
// blanks leading zeros, and stretches the counter's wrap pulse into an LED flash.
module bcd_scan_display #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned STRETCH  = 5000000
) (
    input  logic        clk,
    input  logic        rst_N,
    input  logic [11:0] number_BCD,
    input  logic        carry_in,
    input  logic        blank_SW,
    output logic [7:0]  seg,
    output logic [2:0]  digit_sel,
    output logic        carry_LED
);

    localparam int unsigned PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned STR_W = (STRETCH > 1) ? $clog2(STRETCH + 1) : 1;
    localparam int unsigned BCD_W = 12;

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(SCAN_DIV - 1);
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH);

    localparam logic [7:0] SEG_ZERO  = 8'hC0;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [2:0] SEL_ONES = 3'b110;
    localparam logic [2:0] SEL_TENS = 3'b101;
    localparam logic [2:0] SEL_HUND = 3'b011;

    // Index of the digit currently driven on the anodes
    typedef enum logic [1:0] {
        DIG_ONES = 2'd0,
        DIG_TENS = 2'd1,
        DIG_HUND = 2'd2
    } dig_e;

    dig_e             state;
    dig_e             state_nxt;
    logic [PRE_W-1:0] prescaler;
    logic             tick_c;
    logic [BCD_W-1:0] frame;
    logic [BCD_W-1:0] frame_nxt;
    logic [BCD_W-1:0] src_c;
    logic [7:0]       seg_nxt;
    logic [2:0]       sel_nxt;
    logic [STR_W-1:0] stretch_cnt;

    // Active-low segment pattern for one BCD nibble; non-decimal nibbles show a dash
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'd0:    pat = 8'hC0;
            4'd1:    pat = 8'hF9;
            4'd2:    pat = 8'hA4;
            4'd3:    pat = 8'hB0;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h92;
            4'd6:    pat = 8'h82;
            4'd7:    pat = 8'hF8;
            4'd8:    pat = 8'h80;
            4'd9:    pat = 8'h90;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

    assign tick_c = (prescaler == PRE_MAX);

    // Dwell prescaler: one tick every SCAN_DIV cycles
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            prescaler <= '0;
        end else if (tick_c) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // Digit index state register
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state <= DIG_ONES;
        end else begin
            state <= state_nxt;
        end
    end

    // Next digit, frame snapshot on the 2->0 wrap, and the new segment/anode pattern
    always_comb begin
        state_nxt = state;
        frame_nxt = frame;
        src_c     = frame;
        seg_nxt   = seg;
        sel_nxt   = digit_sel;
        if (tick_c) begin
            case (state)
                DIG_ONES: state_nxt = DIG_TENS;
                DIG_TENS: state_nxt = DIG_HUND;
                DIG_HUND: begin
                    state_nxt = DIG_ONES;
                    frame_nxt = number_BCD;
                    src_c     = number_BCD;
                end
                default:  state_nxt = DIG_ONES;
            endcase
            case (state_nxt)
                DIG_TENS: begin
                    sel_nxt = SEL_TENS;
                    if (blank_SW && (src_c[11:8] == 4'd0) && (src_c[7:4] == 4'd0)) begin
                        seg_nxt = SEG_BLANK;
                    end else begin
                        seg_nxt = seg_decode(src_c[7:4]);
                    end
                end
                DIG_HUND: begin
                    sel_nxt = SEL_HUND;
                    if (blank_SW && (src_c[11:8] == 4'd0)) begin
                        seg_nxt = SEG_BLANK;
                    end else begin
                        seg_nxt = seg_decode(src_c[11:8]);
                    end
                end
                default: begin
                    sel_nxt = SEL_ONES;
                    seg_nxt = seg_decode(src_c[3:0]);
                end
            endcase
        end
    end

    // Registered display drive and frame register
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            seg       <= SEG_ZERO;
            digit_sel <= SEL_ONES;
            frame     <= '0;
        end else begin
            seg       <= seg_nxt;
            digit_sel <= sel_nxt;
            frame     <= frame_nxt;
        end
    end

    // Wrap-pulse stretcher; a new pulse restarts the full hold time
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            stretch_cnt <= '0;
        end else if (carry_in) begin
            stretch_cnt <= STR_LOAD;
        end else if (stretch_cnt != '0) begin
            stretch_cnt <= stretch_cnt - STR_W'(1);
        end
    end

    assign carry_LED = (stretch_cnt != '0);

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display with SCAN_DIV=4, STRETCH=5.
// Expected digit patterns are queued per frame and drained at each tick edge.
module tb_bcd_scan_display;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned STRETCH  = 5;

    logic        clk = 1'b0;
    logic        rst_N;
    logic [11:0] number_BCD;
    logic        carry_in;
    logic        blank_SW;
    logic [7:0]  seg;
    logic [2:0]  digit_sel;
    logic        carry_LED;

    bcd_scan_display #(
        .SCAN_DIV (SCAN_DIV),
        .STRETCH  (STRETCH)
    ) dut (
        .clk        (clk),
        .rst_N      (rst_N),
        .number_BCD (number_BCD),
        .carry_in   (carry_in),
        .blank_SW   (blank_SW),
        .seg        (seg),
        .digit_sel  (digit_sel),
        .carry_LED  (carry_LED)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] seg;
        logic [2:0] sel;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          ecnt  = 0;
    logic [7:0]  last_seg;
    logic [2:0]  last_sel;

    // Segment table for a decimal digit; anything else is a dash
    function automatic logic [7:0] dec(input logic [3:0] n);
        case (n)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    // Expected pattern for position pos (0 ones, 1 tens, 2 hundreds) of value v
    function automatic logic [7:0] exp_seg(input logic [11:0] v, input logic blank, input int pos);
        logic [3:0] o;
        logic [3:0] t;
        logic [3:0] h;
        o = v[3:0];
        t = v[7:4];
        h = v[11:8];
        if (pos == 2) return (blank && h == 4'd0) ? 8'hFF : dec(h);
        if (pos == 1) return (blank && h == 4'd0 && t == 4'd0) ? 8'hFF : dec(t);
        return dec(o);
    endfunction

    function automatic logic [2:0] exp_sel(input int pos);
        logic [2:0] s;
        s = 3'b001 << pos;
        return ~s;
    endfunction

    task automatic push_digit(input logic [11:0] v, input logic blank, input int pos);
        exp_t e;
        e.seg = exp_seg(v, blank, pos);
        e.sel = exp_sel(pos);
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [11:0] v, input logic blank);
        for (int p = 0; p < 3; p++) push_digit(v, blank, p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    // Run n scan ticks: pop and compare at tick edges, check hold between ticks
    task automatic drain_scoreboard(input int n, input string tag);
        int   done;
        int   guard;
        exp_t e;
        done  = 0;
        guard = 0;
        while (done < n && guard < 4 * SCAN_DIV * (n + 1)) begin
            step();
            guard++;
            if (ecnt % SCAN_DIV == 0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s: tick at edge %0d with empty scoreboard, seg=%h sel=%b",
                             tag, ecnt, seg, digit_sel);
                end else begin
                    e = exp_q.pop_front();
                    if (seg !== e.seg || digit_sel !== e.sel) begin
                        bad++;
                        $display("FAIL %s: edge %0d got seg=%h sel=%b want seg=%h sel=%b",
                                 tag, ecnt, seg, digit_sel, e.seg, e.sel);
                    end
                    last_seg = e.seg;
                    last_sel = e.sel;
                end
                done++;
            end else begin
                total++;
                if (seg !== last_seg || digit_sel !== last_sel) begin
                    bad++;
                    $display("FAIL %s_hold: edge %0d got seg=%h sel=%b want seg=%h sel=%b",
                             tag, ecnt, seg, digit_sel, last_seg, last_sel);
                end
            end
        end
        if (done < n) begin
            total++;
            bad++;
            $display("FAIL %s: only %0d of %0d ticks seen", tag, done, n);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_N    = 1'b1;
        ecnt     = 0;
        last_seg = 8'hC0;
        last_sel = 3'b110;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_N      = 1'b0;
        number_BCD = 12'h000;
        carry_in   = 1'b0;
        blank_SW   = 1'b0;
        #12;
        total++;
        if (seg !== 8'hC0 || digit_sel !== 3'b110 || carry_LED !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: seg=%h sel=%b led=%b want seg=c0 sel=110 led=0",
                     seg, digit_sel, carry_LED);
        end
        release_reset();
        push_digit(12'h000, 1'b0, 1);
        push_digit(12'h000, 1'b0, 2);
        drain_scoreboard(2, "first_ticks");
    endtask

    task automatic test_scan_order();
        number_BCD = 12'h123;
        blank_SW   = 1'b0;
        push_frame(12'h123, 1'b0);
        push_frame(12'h123, 1'b0);
        drain_scoreboard(6, "scan_order");
    endtask

    task automatic test_async_reset();
        number_BCD = 12'h123;
        push_frame(12'h123, 1'b0);
        drain_scoreboard(3, "pre_reset");
        step();
        #2;
        rst_N = 1'b0;
        #1;
        total++;
        if (seg !== 8'hC0 || digit_sel !== 3'b110 || carry_LED !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: seg=%h sel=%b led=%b want seg=c0 sel=110 led=0",
                     seg, digit_sel, carry_LED);
        end
        release_reset();
        // Frame register is cleared, so 123 on the input must not show yet
        push_digit(12'h000, 1'b0, 1);
        push_digit(12'h000, 1'b0, 2);
        drain_scoreboard(2, "after_reset");
    endtask

    task automatic test_no_tearing();
        number_BCD = 12'h123;
        blank_SW   = 1'b0;
        push_frame(12'h123, 1'b0);
        drain_scoreboard(2, "tear_a");
        number_BCD = 12'h456;
        drain_scoreboard(1, "tear_b");
        push_frame(12'h456, 1'b0);
        drain_scoreboard(3, "tear_next");
    endtask

    task automatic test_blanking();
        logic [11:0] vals[6];
        logic        blk[6];
        vals = '{12'h007, 12'h105, 12'h007, 12'h105, 12'h0A0, 12'h0A0};
        blk  = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b0,    1'b1};
        for (int i = 0; i < 6; i++) begin
            number_BCD = vals[i];
            blank_SW   = blk[i];
            push_frame(vals[i], blk[i]);
            drain_scoreboard(3, $sformatf("blank_%03h_%0d", vals[i], blk[i]));
        end
    endtask

    // One stretch scenario; pulses at p1/p2 (-1 = none), reset asserted in cycle rst_at
    task automatic run_stretch(input int p1, input int p2, input int rst_at, input string tag);
        logic want;
        step();
        for (int c = 0; c < 22; c++) begin
            carry_in = (c == p1 || c == p2);
            if (c == rst_at) begin
                #2;
                rst_N = 1'b0;
                #1;
                total++;
                if (carry_LED !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_rst: led=%b want 0", tag, carry_LED);
                end
                carry_in = 1'b0;
                break;
            end
            step();
            want = ((p1 >= 0) && (c + 1 > p1) && (c + 1 <= p1 + int'(STRETCH))) ||
                   ((p2 >= 0) && (c + 1 > p2) && (c + 1 <= p2 + int'(STRETCH)));
            total++;
            if (carry_LED !== want) begin
                bad++;
                $display("FAIL %s: cycle %0d led=%b want %b", tag, c + 1, carry_LED, want);
            end
        end
        carry_in = 1'b0;
        if (rst_at >= 0) release_reset();
    endtask

    task automatic test_stretch();
        run_stretch(10, -1, -1, "stretch");
        run_stretch(10, 13, -1, "retrigger");
        run_stretch(10, -1, 12, "stretch_reset");
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_async_reset();
        test_no_tearing();
        test_blanking();
        test_stretch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
